// File: rtl/r5p_mouse_cpu.sv
// Minimal multi-cycle RV32I core: fetch, GPR access and load/store all share one TCB bus.
// The register file lives in system memory at GPR_ADR, so the core holds only PC and operands.
module r5p_mouse_cpu #(
  parameter logic [31:0] IFU_RST = 32'h8000_0000,
  parameter logic [31:0] IFU_MSK = 32'h803f_ffff,
  parameter logic [31:0] GPR_ADR = 32'h801f_ff80
)(
  input  logic        clk,
  input  logic        rst,
  output logic        tcb_vld,
  output logic        tcb_wen,
  output logic [31:0] tcb_adr,
  output logic [2:0]  tcb_fn3,
  output logic [31:0] tcb_wdt,
  input  logic [31:0] tcb_rdt,
  input  logic        tcb_err,
  input  logic        tcb_rdy
);

  typedef enum logic [2:0] {PH_IF = 3'd0, PH_RS1 = 3'd1, PH_RS2 = 3'd2, PH_MEM = 3'd3, PH_WB = 3'd4} pha_t;

  pha_t        ctl_pha, lst_pha, cur_pha, nxt_pha, fst_pha, wb_pha;
  logic        run, rsp, fin, dec, taken;
  logic [31:0] pc, ir, rs1_r, rs2_r, ld_r;
  logic [31:0] inst, raw1, raw2, x1, x2, ldv, res, pc_nxt, fpc;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic        unused_err;

  assign unused_err = tcb_err;

  // Read data is only valid the cycle after its transfer, so use it directly then, registered copy after.
  assign dec  = rsp && (lst_pha == PH_IF);
  assign inst = dec ? tcb_rdt : ir;
  assign raw1 = (rsp && lst_pha == PH_RS1) ? tcb_rdt : rs1_r;
  assign raw2 = (rsp && lst_pha == PH_RS2) ? tcb_rdt : rs2_r;
  assign ldv  = (rsp && lst_pha == PH_MEM) ? tcb_rdt : ld_r;

  assign opc   = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_br    = (opc == 7'b1100011);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_op    = (opc == 7'b0110011);

  assign x1 = (rs1 == 5'd0) ? 32'd0 : raw1;
  assign x2 = (rs2 == 5'd0) ? 32'd0 : raw2;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    case (f3)
      3'd0:    taken = (x1 == x2);
      3'd1:    taken = (x1 != x2);
      3'd4:    taken = ($signed(x1) < $signed(x2));
      3'd5:    taken = ($signed(x1) >= $signed(x2));
      3'd6:    taken = (x1 < x2);
      3'd7:    taken = (x1 >= x2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res = 32'd0;
    if (is_lui)                 res = imm_u;
    else if (is_auipc)          res = pc + imm_u;
    else if (is_jal || is_jalr) res = pc + 32'd4;
    else if (is_opi)            res = alu(x1, imm_i, f3, (f3 == 3'd5) && inst[30]);
    else if (is_op)             res = alu(x1, x2, f3, inst[30]);
    else if (is_ld)             res = ldv;
  end

  always_comb begin
    pc_nxt = pc + 32'd4;
    if (is_jal)              pc_nxt = pc + imm_j;
    else if (is_jalr)        pc_nxt = (x1 + imm_i) & ~32'd1;
    else if (is_br && taken) pc_nxt = pc + imm_b;
  end

  // The phase right after a fetch is decided from the instruction as it arrives on the bus.
  always_comb begin
    wb_pha = (rd == 5'd0) ? PH_IF : PH_WB;
    if (is_lui || is_auipc || is_jal)                          fst_pha = wb_pha;
    else if (is_opi || is_jalr || is_ld || is_op || is_st || is_br) fst_pha = PH_RS1;
    else                                                       fst_pha = PH_IF;
    cur_pha = dec ? fst_pha : ctl_pha;
    case (cur_pha)
      PH_RS1:  nxt_pha = (is_opi || is_jalr) ? wb_pha : (is_ld ? PH_MEM : PH_RS2);
      PH_RS2:  nxt_pha = is_op ? wb_pha : (is_st ? PH_MEM : PH_IF);
      PH_MEM:  nxt_pha = is_ld ? wb_pha : PH_IF;
      default: nxt_pha = PH_IF;
    endcase
  end

  assign fpc = (fin || dec) ? pc_nxt : pc;

  always_comb begin
    tcb_vld = run;
    tcb_wen = 1'b0;
    tcb_fn3 = 3'b010;
    tcb_adr = 32'd0;
    tcb_wdt = 32'd0;
    case (cur_pha)
      PH_IF:  tcb_adr = fpc & IFU_MSK;
      PH_RS1: tcb_adr = GPR_ADR + {25'b0, rs1, 2'b00};
      PH_RS2: tcb_adr = GPR_ADR + {25'b0, rs2, 2'b00};
      PH_MEM: begin
        tcb_adr = x1 + (is_st ? imm_s : imm_i);
        tcb_fn3 = f3;
        tcb_wen = is_st;
        tcb_wdt = is_st ? x2 : 32'd0;
      end
      PH_WB: begin
        tcb_adr = GPR_ADR + {25'b0, rd, 2'b00};
        tcb_wen = 1'b1;
        tcb_wdt = res;
      end
      default: tcb_adr = 32'd0;
    endcase
    if (!run) begin
      tcb_vld = 1'b0;
      tcb_wen = 1'b0;
      tcb_fn3 = 3'b000;
      tcb_adr = 32'd0;
      tcb_wdt = 32'd0;
    end
  end

  // PC keeps the current instruction's address until the next fetch, where pc_nxt gets latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run     <= 1'b0;
      ctl_pha <= PH_IF;
      lst_pha <= PH_IF;
      rsp     <= 1'b0;
      fin     <= 1'b0;
      pc      <= IFU_RST;
      ir      <= 32'd0;
      rs1_r   <= 32'd0;
      rs2_r   <= 32'd0;
      ld_r    <= 32'd0;
    end else begin
      run <= 1'b1;
      if (rsp) begin
        case (lst_pha)
          PH_IF:   ir    <= tcb_rdt;
          PH_RS1:  rs1_r <= tcb_rdt;
          PH_RS2:  rs2_r <= tcb_rdt;
          PH_MEM:  ld_r  <= tcb_rdt;
          default: ld_r  <= ld_r;
        endcase
      end
      rsp     <= tcb_vld && tcb_rdy && !tcb_wen;
      lst_pha <= cur_pha;
      if (run && cur_pha == PH_IF && (fin || dec)) begin
        pc  <= pc_nxt;
        fin <= 1'b0;
      end
      if (tcb_vld && tcb_rdy) begin
        ctl_pha <= nxt_pha;
        if (cur_pha != PH_IF && nxt_pha == PH_IF) fin <= 1'b1;
      end else begin
        ctl_pha <= cur_pha;
      end
    end
  end

endmodule

// File: tb/tb_r5p_mouse_cpu.sv
// Scoreboard bench for r5p_mouse_cpu: a TCB memory model serves the bus while a monitor
// compares every transfer against hand-computed expected transfers queued per program.
module tb_r5p_mouse_cpu;

  localparam logic [31:0] GPR    = 32'h801f_ff80;
  localparam logic [31:0] TOHOST = 32'h8000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tcb_vld, tcb_wen, tcb_err, tcb_rdy;
  logic [31:0] tcb_adr, tcb_wdt, tcb_rdt;
  logic [2:0]  tcb_fn3;

  typedef struct packed {
    logic        wen;
    logic [31:0] adr;
    logic [2:0]  fn3;
    logic [31:0] wdt;
    logic [31:0] msk;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] mem [logic [29:0]];
  int          errors = 0;
  int          checks = 0;
  bit          sb_on = 1'b0;
  bit          done = 1'b0;

  always #5 clk = ~clk;

  r5p_mouse_cpu dut (
    .clk     (clk),
    .rst     (rst),
    .tcb_vld (tcb_vld),
    .tcb_wen (tcb_wen),
    .tcb_adr (tcb_adr),
    .tcb_fn3 (tcb_fn3),
    .tcb_wdt (tcb_wdt),
    .tcb_rdt (tcb_rdt),
    .tcb_err (tcb_err),
    .tcb_rdy (tcb_rdy)
  );

  function automatic logic [31:0] rdWord(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'd0;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] sh;
    sh = rdWord(a) >> (8 * a[1:0]);
    case (f)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  task automatic memWrite(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w;
    w = rdWord(a);
    case (f[1:0])
      2'd0:    w[8*a[1:0] +: 8] = d[7:0];
      2'd1:    w[16*a[1] +: 16] = d[15:0];
      default: w = d;
    endcase
    mem[a[31:2]] = w;
  endtask

  // Bus slave with one cycle of read delay; between responses the read bus carries junk.
  always @(posedge clk) begin
    if (tcb_vld && tcb_rdy && !tcb_wen) begin
      tcb_rdt <= memRead(tcb_adr, tcb_fn3);
    end else begin
      if (tcb_vld && tcb_rdy) memWrite(tcb_adr, tcb_fn3, tcb_wdt);
      tcb_rdt <= 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    xfer_t e;
    if (!rst && sb_on && !done && tcb_vld && tcb_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL xfer: unexpected adr=%h wen=%b fn3=%b wdt=%h", tcb_adr, tcb_wen, tcb_fn3, tcb_wdt);
      end else begin
        e = exp_q.pop_front();
        if (tcb_wen !== e.wen || tcb_adr !== e.adr || tcb_fn3 !== e.fn3 ||
            (tcb_wdt & e.msk) !== (e.wdt & e.msk)) begin
          errors++;
          $display("[TB] FAIL xfer: got adr=%h wen=%b fn3=%b wdt=%h, expected adr=%h wen=%b fn3=%b wdt=%h (mask %h)",
                   tcb_adr, tcb_wen, tcb_fn3, tcb_wdt, e.adr, e.wen, e.fn3, e.wdt, e.msk);
        end
      end
      if (tcb_wen && tcb_adr == TOHOST) done = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] g(input int n);
    return GPR + 32'(4 * n);
  endfunction

  task automatic expF(input logic [31:0] a);
    exp_q.push_back('{1'b0, a, 3'b010, 32'd0, 32'd0});
  endtask

  task automatic expR(input logic [31:0] a, input logic [2:0] f);
    exp_q.push_back('{1'b0, a, f, 32'd0, 32'd0});
  endtask

  task automatic expW(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input logic [31:0] m);
    exp_q.push_back('{1'b1, a, f, d, m});
  endtask

  task automatic holdReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_vld", {31'd0, tcb_vld}, 32'd0);
      checkOutput("rst_adr", tcb_adr, 32'd0);
    end
    rst = 1'b0;
    done = 1'b0;
    sb_on = 1'b1;
  endtask

  // Runs until the tohost store; optionally holds ready low for 3 cycles on the byte store.
  task automatic applyStimulus(input bit do_stall);
    bit stalled = 1'b0;
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (do_stall && !stalled && tcb_vld && tcb_wen && tcb_adr == 32'h8000_1000) begin
        stalled = 1'b1;
        tcb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
          checkOutput("stall_adr", tcb_adr, 32'h8000_1000);
          checkOutput("stall_ctl", {27'd0, tcb_vld, tcb_wen, tcb_fn3}, {27'd0, 1'b1, 1'b1, 3'b000});
          checkOutput("stall_wdt", {24'd0, tcb_wdt[7:0]}, 32'h0000_00AB);
          @(posedge clk);
          #1;
        end
        tcb_rdy = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no tohost store after %0d cycles, expected one", n);
    end
    if (do_stall) checkOutput("stall_seen", {31'd0, stalled}, 32'd1);
    checkOutput("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    tcb_rdy = 1'b1;
    tcb_err = 1'b0;

    mem[GPR[31:2]] = 32'hFFFF_FFFF;
    mem[30'h2000_0400] = 32'h0000_8000;
    mem[30'h2000_0000] = 32'h0050_0093;  // addi x1,x0,5
    mem[30'h2000_0001] = 32'h1234_5137;  // lui  x2,0x12345
    mem[30'h2000_0002] = 32'h6AB1_0113;  // addi x2,x2,0x6ab
    mem[30'h2000_0003] = 32'h8000_11B7;  // lui  x3,0x80001
    mem[30'h2000_0004] = 32'h0021_8023;  // sb   x2,0(x3)
    mem[30'h2000_0005] = 32'h0011_8203;  // lb   x4,1(x3)
    mem[30'h2000_0006] = 32'h0011_C283;  // lbu  x5,1(x3)
    mem[30'h2000_0007] = 32'h4052_0333;  // sub  x6,x4,x5
    mem[30'h2000_0008] = 32'h4043_5393;  // srai x7,x6,4
    mem[30'h2000_0009] = 32'h0062_B433;  // sltu x8,x5,x6
    mem[30'h2000_000A] = 32'h0053_24B3;  // slt  x9,x6,x5
    mem[30'h2000_000B] = 32'h0004_1463;  // bne  x8,x0,+8
    mem[30'h2000_000C] = 32'h0010_0093;  // skipped
    mem[30'h2000_000D] = 32'h0070_8013;  // addi x0,x1,7
    mem[30'h2000_000E] = 32'h0010_0513;  // addi x10,x0,1
    mem[30'h2000_000F] = 32'h8000_35B7;  // lui  x11,0x80003
    mem[30'h2000_0010] = 32'h00A5_A023;  // sw   x10,0(x11)

    expF(32'h8000_0000); expR(g(0), 3'b010); expW(g(1), 3'b010, 32'd5, '1);
    expF(32'h8000_0004); expW(g(2), 3'b010, 32'h1234_5000, '1);
    expF(32'h8000_0008); expR(g(2), 3'b010); expW(g(2), 3'b010, 32'h1234_56AB, '1);
    expF(32'h8000_000C); expW(g(3), 3'b010, 32'h8000_1000, '1);
    expF(32'h8000_0010); expR(g(3), 3'b010); expR(g(2), 3'b010);
    expW(32'h8000_1000, 3'b000, 32'h0000_00AB, 32'h0000_00FF);
    expF(32'h8000_0014); expR(g(3), 3'b010); expR(32'h8000_1001, 3'b000); expW(g(4), 3'b010, 32'hFFFF_FF80, '1);
    expF(32'h8000_0018); expR(g(3), 3'b010); expR(32'h8000_1001, 3'b100); expW(g(5), 3'b010, 32'h0000_0080, '1);
    expF(32'h8000_001C); expR(g(4), 3'b010); expR(g(5), 3'b010); expW(g(6), 3'b010, 32'hFFFF_FF00, '1);
    expF(32'h8000_0020); expR(g(6), 3'b010); expW(g(7), 3'b010, 32'hFFFF_FFF0, '1);
    expF(32'h8000_0024); expR(g(5), 3'b010); expR(g(6), 3'b010); expW(g(8), 3'b010, 32'd1, '1);
    expF(32'h8000_0028); expR(g(6), 3'b010); expR(g(5), 3'b010); expW(g(9), 3'b010, 32'd1, '1);
    expF(32'h8000_002C); expR(g(8), 3'b010); expR(g(0), 3'b010);
    expF(32'h8000_0034); expR(g(1), 3'b010);
    expF(32'h8000_0038); expR(g(0), 3'b010); expW(g(10), 3'b010, 32'd1, '1);
    expF(32'h8000_003C); expW(g(11), 3'b010, 32'h8000_3000, '1);
    expF(32'h8000_0040); expR(g(11), 3'b010); expR(g(10), 3'b010); expW(TOHOST, 3'b010, 32'd1, '1);

    holdReset();
    applyStimulus(1'b1);

    // Reset while the core is busy must clear the bus immediately, without waiting for a clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb_on = 1'b0;
    #1;
    checkOutput("async_vld", {31'd0, tcb_vld}, 32'd0);
    checkOutput("async_adr", tcb_adr, 32'd0);

    exp_q.delete();
    mem[30'h2000_0000] = 32'h0080_00EF;  // jal  x1,+8
    mem[30'h2000_0001] = 32'h0015_A023;  // sw   x1,0(x11)
    mem[30'h2000_0002] = 32'hFE00_0EE3;  // beq  x0,x0,-4
    expF(32'h8000_0000); expW(g(1), 3'b010, 32'h8000_0004, '1);
    expF(32'h8000_0008); expR(g(0), 3'b010); expR(g(0), 3'b010);
    expF(32'h8000_0004); expR(g(11), 3'b010); expR(g(1), 3'b010); expW(TOHOST, 3'b010, 32'h8000_0004, '1);

    holdReset();
    applyStimulus(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
